// File: rtl/clk_div_sched.sv
// clk_div_sched: divide-by-N clock-enable controller.
// Produces a one-cycle tick at the end of every period and a near-50% gate
// (div_out). Start/stop and ratio changes only take effect on whole-period
// boundaries.
//
// Handshake: a request is accepted in a cycle where div_req=1, div_busy=0 and
// div_ack=0. div_val is captured on that edge. div_ack pulses for exactly one
// cycle when the change is applied (or rejected, with div_err). The requester
// drops div_req in the cycle it sees div_ack. A div_req still high in the
// following cycle is treated as a new request.
module clk_div_sched #(
  parameter int W           = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         div_req,
  input  logic [W-1:0] div_val,
  output logic         div_ack,
  output logic         div_err,
  output logic         div_busy,
  output logic         tick,
  output logic         div_out,
  output logic [W-1:0] phase,
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] RESET_N  = W'(DEFAULT_DIV);

  state_t       state;
  logic [W-1:0] counter;
  logic [W-1:0] ratio;
  logic [W-1:0] pending;
  logic         busy;
  logic         ack;
  logic         err;

  logic         active;
  logic         at_end;
  logic [W:0]   half_n;
  logic         accept;

  assign active = (state != IDLE);
  assign at_end = (counter == (ratio - ONE));
  // ceil(N/2), one bit wider so N = 2^W-1 does not wrap
  assign half_n = ({1'b0, ratio} + {{W{1'b0}}, 1'b1}) >> 1;
  assign accept = div_req && !busy && !ack;

  assign tick      = active && at_end;
  assign div_out   = active && ({1'b0, counter} < half_n);
  assign phase     = counter;
  assign div_ack   = ack;
  assign div_err   = err;
  assign div_busy  = busy;
  assign fsm_state = state;

  // Run/stop sequencing, period counter and ratio-change handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      ratio   <= RESET_N;
      pending <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;

      case (state)
        IDLE: begin
          counter <= '0;
          if (en) state <= RUN;
        end
        RUN, STOP: begin
          if (at_end) begin
            // boundary: only here may the machine go idle
            counter <= '0;
            state   <= en ? RUN : IDLE;
          end else begin
            counter <= counter + ONE;
            state   <= en ? RUN : STOP;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase

      // Pending change lands on a boundary (or at once if the divider has
      // already gone idle); the counter restart above is then under new N.
      if (busy && (state == IDLE || at_end)) begin
        ratio <= pending;
        busy  <= 1'b0;
        ack   <= 1'b1;
      end else if (accept) begin
        if (div_val == '0) begin
          ack <= 1'b1;
          err <= 1'b1;
        end else if (state == IDLE) begin
          ratio <= div_val;
          ack   <= 1'b1;
        end else begin
          pending <= div_val;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Programmable clock-enable divider controller for the ring-counter clock-division datapath. It produces a divide-by-N tick and a near-50% gate waveform from the single system clock. It also sequences start/stop and run-time ratio changes so that no period is truncated or glitched. Requesters change the ratio through a req/ack handshake, and the change is applied only on a period boundary.

Parameters:
W, 4, width of divide ratio and phase counter
DEFAULT_DIV, 3, ratio loaded at reset; must be 1..2^W-1

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next clk edge
en  input  1  run request, level-sensitive
div_req  input  1  ratio-change request
div_val  input  W  requested ratio; must be held stable while div_req=1
div_ack  output  1  one-cycle pulse: requested ratio applied (or rejected)
div_err  output  1  one-cycle pulse coincident with div_ack when div_val=0 was rejected
div_busy  output  1  a change is accepted and pending
tick  output  1  one-cycle pulse in the last cycle of each period
div_out  output  1  divided waveform
phase  output  W  current period counter value

Behaviour:
- Reset:
  - state=IDLE, counter=0, ratio=DEFAULT_DIV, pending cleared.
  - div_ack=div_err=div_busy=tick=div_out=0, phase=0.
  - Reset mid-period or mid-handshake takes effect immediately; any pending request is dropped and no ack is issued.
- States:
  - IDLE: counter held at 0; tick=0; div_out=0.
  - RUN: counter counts 0..N-1 and wraps to 0.
  - STOP: draining; counting continues to the end of the current period.
- Transitions:
  - IDLE -> RUN when en=1 sampled. Next cycle: counter=0, div_out=1.
  - RUN -> STOP when en=0 sampled.
  - STOP -> RUN when en=1 sampled; counting continues uninterrupted.
  - STOP -> IDLE on the cycle after a boundary (counter=N-1) with en=0.
- Period outputs (RUN or STOP only):
  - tick=1 iff counter==N-1.
  - div_out=1 iff counter < ceil(N/2).
  - phase=counter.
  - N=1: tick=1 and div_out=1 every cycle.
  - N=2^W-1: counter reaches all-ones except LSB; no overflow.
- Request acceptance:
  - A request is accepted in a cycle with div_req=1, div_busy=0 and div_ack=0.
  - div_val is latched into pending and div_busy=1 from the next cycle.
  - Requester must drop div_req in the cycle it sees div_ack. A req still high in the following cycle is a new request.
- Apply, RUN/STOP:
  - The pending ratio is applied at the first boundary strictly after the acceptance cycle.
  - An acceptance in a tick cycle waits for the next boundary.
  - In the cycle after that boundary: counter=0 under the new N, div_ack=1, div_busy=0.
- Apply, IDLE:
  - Ratio updated and div_ack=1 in the cycle after acceptance.
- Rejection:
  - div_val=0 is rejected: div_ack=1 and div_err=1 in the cycle after acceptance, in any state.
  - Ratio unchanged; div_busy never asserted.
- Simultaneous events:
  - Boundary with pending change and en=0 in STOP: the ratio is applied and acked, and the state goes IDLE in the same cycle.
  - en toggling never truncates a period: div_out/tick sequences are always whole periods.
- Latency:
  - en=1 to first tick: N cycles after RUN entry.
  - Request to ack: at most 2N cycles while running.

Test Plan:
- Reset, then en=1 with DEFAULT_DIV=3: phase 0,1,2,0...; div_out 1,1,0 repeating; tick on phase 2. All outputs 0 during reset.
- Running N=3, div_req with div_val=5 at phase 0: busy for the rest of this period; ack in the cycle after the tick at phase 2; then div_out 1,1,1,0,0 with tick at phase 4.
- div_req with div_val=4 presented in a tick cycle: not applied at that boundary; applied one full period later; single ack pulse.
- en dropped at phase 1 with N=5: phases 2,3,4 still run with tick at 4, then IDLE with div_out=0. en re-raised at phase 3 instead: no gap or restart.
- div_val=0 request: div_ack=div_err=1 for one cycle; ratio and waveform unchanged. div_val=1: tick and div_out constant 1 after ack.
- reset asserted while busy=1 mid-period: next cycle IDLE, ratio=DEFAULT_DIV, no ack; a subsequent request in IDLE acks exactly one cycle after acceptance.
